dcache_l2_nway: RTL and testbench
=================================

DCACHE_L2_NWAY -- requirements
Module: dcache_l2_nway

Interface
REQ-001 SHALL have parameter SET_BITS, default 3, set-index width (2^SET_BITS sets).
REQ-002 SHALL have parameter WAY_BITS, default 2, way-index width (2^WAY_BITS ways, legal 1..3).
REQ-003 SHALL have parameter ADDR_W, default 28, line-address width.
REQ-004 SHALL have parameter LINE_W, default 128, line data width.
REQ-005 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have ports: proc_reset  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports: proc_read / proc_write  in  1 each  processor request strobes.
REQ-008 SHALL have ports: proc_addr  in  ADDR_W  line address; proc_wdata  in  LINE_W  write line.
REQ-009 SHALL have ports: proc_rdata  out  LINE_W  read line; proc_ready  out  1  request-done pulse.
REQ-010 SHALL have ports: mem_read / mem_write  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  LINE_W.
REQ-011 SHALL have ports: mem_rdata  in  LINE_W; mem_ready  in  1  memory completion.

Function
REQ-012 SHALL split proc_addr as set = [SET_BITS-1:0], tag = [ADDR_W-1:SET_BITS].
REQ-013 SHALL treat proc_read&proc_write both high, or both low, as no request (no state change, proc_ready 0).
REQ-014 SHALL be write-back, write-allocate without fetch (write miss installs proc_wdata, dirty=1).
REQ-015 SHALL, on hit in IDLE, assert proc_ready combinationally in the same cycle; read hit drives proc_rdata = hit line; write hit updates line, dirty=1.
REQ-016 SHALL select victim as lowest-index invalid way, else the way with maximum LRU age.
REQ-017 SHALL keep per-way WAY_BITS-bit age; on any hit/install to way w: ages < age[w] +1, age[w]=0; ages stay a permutation of 0..2^WAY_BITS-1.
REQ-018 SHALL implement states IDLE, WB, FILL, WB_WR.
REQ-019 SHALL, on read miss with dirty victim: IDLE->WB; clean victim: IDLE->FILL; write miss dirty victim: IDLE->WB_WR; write miss clean victim: install in IDLE, proc_ready same cycle.
REQ-020 SHALL register mem_ready into mem_ready_q; state transitions out of WB/FILL/WB_WR occur only on mem_ready_q=1.
REQ-021 SHALL hold mem_write, mem_addr={victim tag,set}, mem_wdata=victim line during WB/WB_WR until mem_ready_q.
REQ-022 SHALL, WB on mem_ready_q: clear victim dirty, go FILL asserting mem_read, mem_addr={tag,set} same cycle.
REQ-023 SHALL, FILL on mem_ready_q: install mem_rdata (valid=1, dirty=0), drive proc_rdata=mem_rdata, proc_ready=1, go IDLE.
REQ-024 SHALL, WB_WR on mem_ready_q: install proc_wdata dirty=1, proc_ready=1, go IDLE.
REQ-025 SHALL require processor to hold request and address stable until proc_ready; behaviour otherwise undefined.
REQ-026 SHALL drive proc_rdata, mem_addr, mem_wdata to 0 whenever not specified above.

Reset
REQ-027 SHALL, on proc_reset asserted (any cycle, mid-transaction included), immediately: state=IDLE, mem_ready_q=0, all valid/dirty=0, ages = way index, tags/data=0; mem_read/mem_write/proc_ready drop to 0 without waiting for clk.

Configuration
REQ-028 SHALL, with DCACHE_L2_STATS_EN defined, add outputs hit_cnt and miss_cnt (32 bits each, reset 0, saturating) counting accepted requests in IDLE; without it, ports and counters are absent and function is otherwise identical.

Structure
REQ-029 SHALL place state encoding enum and default parameter constants in package dcache_l2_pkg.
REQ-030 SHALL implement age update and victim choice in sub-module dcache_lru (per-set, parameterised by WAY_BITS).

Verification
REQ-031 Reset, read 0x0000010 -> mem_read, mem_addr=0x0000010; mem_ready 1 cycle -> proc_ready with proc_rdata=mem_rdata, next read same address hits same cycle.
REQ-032 Write 0x0000008, 0x0000010, 0x0000018, 0x0000020 (set 0, 4 ways) then read 0x0000008 (hit), write 0x0000028 -> victim 0x0000010: mem_write, mem_addr=0x0000010, then install, proc_ready.
REQ-033 Read miss, set 3, all ways dirty -> WB then FILL; mem_write before mem_read, dirty of installed way=0.
REQ-034 proc_read=proc_write=1 for 5 cycles -> no mem activity, proc_ready=0, hit_cnt/miss_cnt unchanged.
REQ-035 proc_reset pulsed mid-FILL -> mem_read low immediately; subsequent read of previously cached address misses.
REQ-036 With DCACHE_L2_STATS_EN, 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/dcache_l2_pkg.sv
// Shared constants and state encoding for the n-way write-back line cache.
package dcache_l2_pkg;

  localparam int DEF_SET_BITS = 3;
  localparam int DEF_WAY_BITS = 2;
  localparam int DEF_ADDR_W   = 28;
  localparam int DEF_LINE_W   = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FILL  = 2'd2,
    WB_WR = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_lru.sv
// Per-set LRU tracker: one age per way (0 = most recent) plus victim choice.
// Victim is the lowest-index invalid way, otherwise the oldest way.
module dcache_lru #(
  parameter int WAY_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [(1<<WAY_BITS)-1:0]  valid_ways,
  input  logic                      upd_en,
  input  logic [WAY_BITS-1:0]       upd_way,
  output logic [WAY_BITS-1:0]       victim
);

  localparam int WAYS = 1 << WAY_BITS;

  logic [WAY_BITS-1:0] age_reg [WAYS];
  logic [WAY_BITS-1:0] upd_age;
  logic [WAY_BITS-1:0] old_way;
  logic [WAY_BITS-1:0] old_age;
  logic [WAY_BITS-1:0] inv_way;
  logic                inv_found;

  assign upd_age = age_reg[upd_way];

  // Touched way becomes youngest; ways younger than it age by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WAYS; i++) age_reg[i] <= WAY_BITS'(i);
    end else if (upd_en) begin
      for (int i = 0; i < WAYS; i++) begin
        if (WAY_BITS'(i) == upd_way)
          age_reg[i] <= '0;
        else if (age_reg[i] < upd_age)
          age_reg[i] <= age_reg[i] + WAY_BITS'(1);
      end
    end
  end

  // Pick the first free way, falling back to the oldest one.
  always_comb begin
    old_way   = '0;
    old_age   = age_reg[0];
    inv_way   = '0;
    inv_found = 1'b0;
    for (int i = 1; i < WAYS; i++) begin
      if (age_reg[i] > old_age) begin
        old_age = age_reg[i];
        old_way = WAY_BITS'(i);
      end
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_ways[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(i);
      end
    end
    victim = inv_found ? inv_way : old_way;
  end

endmodule

// File: rtl/dcache_l2_nway.sv
// N-way set-associative write-back, write-allocate (no fetch on write) line cache.
// Optional hit/miss counters are enabled with the DCACHE_L2_STATS_EN macro.
module dcache_l2_nway
  import dcache_l2_pkg::*;
#(
  parameter int SET_BITS = DEF_SET_BITS,
  parameter int WAY_BITS = DEF_WAY_BITS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LINE_W   = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [LINE_W-1:0] proc_wdata,
  output logic [LINE_W-1:0] proc_rdata,
  output logic              proc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef DCACHE_L2_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int WAYS  = 1 << WAY_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS;

  logic [SETS-1:0][WAYS-1:0]     valid_reg, dirty_reg;
  logic [TAG_W-1:0]              tag_reg  [SETS][WAYS];
  logic [LINE_W-1:0]             data_reg [SETS][WAYS];
  logic [SETS-1:0][WAY_BITS-1:0] victim_all;

  state_e state_reg, state_next;
  logic   mem_ready_q;

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                req_rd, req_wr, req_any;
  logic                hit;
  logic [WAY_BITS-1:0] hit_way, victim;
  logic                vic_dirty;
  logic [LINE_W-1:0]   vic_data;
  logic [ADDR_W-1:0]   vic_line, req_line;

  logic                ready_c, mem_read_c, mem_write_c;
  logic                wr_en, wr_dirty, clean_en, upd_en;
  logic [WAY_BITS-1:0] wr_way, upd_way;
  logic [LINE_W-1:0]   wr_data;

  assign set_idx   = proc_addr[SET_BITS-1:0];
  assign req_tag   = proc_addr[ADDR_W-1:SET_BITS];
  assign req_rd    = proc_read & ~proc_write;
  assign req_wr    = proc_write & ~proc_read;
  assign req_any   = req_rd | req_wr;
  assign victim    = victim_all[set_idx];
  assign vic_dirty = dirty_reg[set_idx][victim];
  assign vic_data  = data_reg[set_idx][victim];
  assign vic_line  = {tag_reg[set_idx][victim], set_idx};
  assign req_line  = {req_tag, set_idx};

  // Strobes fall as soon as reset rises, independent of the clock.
  assign proc_ready = ready_c & ~proc_reset;
  assign mem_read   = mem_read_c & ~proc_reset;
  assign mem_write  = mem_write_c & ~proc_reset;

  // One LRU tracker per set; only the addressed set is updated.
  for (genvar gi = 0; gi < SETS; gi++) begin : g_lru
    dcache_lru #(.WAY_BITS(WAY_BITS)) u_lru (
      .clk        (clk),
      .rst        (proc_reset),
      .valid_ways (valid_reg[gi]),
      .upd_en     (upd_en && (set_idx == SET_BITS'(gi))),
      .upd_way    (upd_way),
      .victim     (victim_all[gi])
    );
  end

  // Tag match across the ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_reg[set_idx][i] && (tag_reg[set_idx][i] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(i);
      end
    end
  end

  // State and registered memory handshake.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_reg   <= IDLE;
      mem_ready_q <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mem_ready_q <= mem_ready;
    end
  end

  // Next state, memory/processor outputs and array write controls.
  always_comb begin
    state_next  = state_reg;
    ready_c     = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    proc_rdata  = '0;
    wr_en       = 1'b0;
    wr_way      = victim;
    wr_data     = proc_wdata;
    wr_dirty    = 1'b1;
    clean_en    = 1'b0;
    upd_en      = 1'b0;
    upd_way     = victim;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          if (hit) begin
            ready_c = 1'b1;
            upd_en  = 1'b1;
            upd_way = hit_way;
            if (req_rd) begin
              proc_rdata = data_reg[set_idx][hit_way];
            end else begin
              wr_en  = 1'b1;
              wr_way = hit_way;
            end
          end else if (req_rd) begin
            state_next = vic_dirty ? WB : FILL;
          end else if (vic_dirty) begin
            state_next = WB_WR;
          end else begin
            // Clean victim on a write miss: install without touching memory.
            wr_en   = 1'b1;
            upd_en  = 1'b1;
            ready_c = 1'b1;
          end
        end
      end
      WB: begin
        if (mem_ready_q) begin
          clean_en   = 1'b1;
          state_next = FILL;
          mem_read_c = 1'b1;
          mem_addr   = req_line;
        end else begin
          mem_write_c = 1'b1;
          mem_addr    = vic_line;
          mem_wdata   = vic_data;
        end
      end
      FILL: begin
        if (mem_ready_q) begin
          wr_en      = 1'b1;
          wr_data    = mem_rdata;
          wr_dirty   = 1'b0;
          upd_en     = 1'b1;
          ready_c    = 1'b1;
          proc_rdata = mem_rdata;
          state_next = IDLE;
        end else begin
          mem_read_c = 1'b1;
          mem_addr   = req_line;
        end
      end
      WB_WR: begin
        if (mem_ready_q) begin
          wr_en      = 1'b1;
          upd_en     = 1'b1;
          ready_c    = 1'b1;
          state_next = IDLE;
        end else begin
          mem_write_c = 1'b1;
          mem_addr    = vic_line;
          mem_wdata   = vic_data;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line arrays; a write always (re)validates the line with the request tag.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      valid_reg <= '0;
      dirty_reg <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_reg[s][w]  <= '0;
          data_reg[s][w] <= '0;
        end
      end
    end else begin
      if (clean_en) dirty_reg[set_idx][victim] <= 1'b0;
      if (wr_en) begin
        valid_reg[set_idx][wr_way] <= 1'b1;
        dirty_reg[set_idx][wr_way] <= wr_dirty;
        tag_reg[set_idx][wr_way]   <= req_tag;
        data_reg[set_idx][wr_way]  <= wr_data;
      end
    end
  end

`ifdef DCACHE_L2_STATS_EN
  logic acc_hit, acc_miss;
  assign acc_hit  = (state_reg == IDLE) && req_any && hit;
  assign acc_miss = (state_reg == IDLE) && req_any && !hit;

  // Saturating counters of requests accepted in IDLE.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (acc_hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 32'd1;
      if (acc_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_l2_nway.sv
// Directed bench for dcache_l2_nway; counter checks are active when
// DCACHE_L2_STATS_EN is defined.
module tb_dcache_l2_nway;

  logic         clk;
  logic         proc_reset, proc_read, proc_write, proc_ready;
  logic         mem_read, mem_write, mem_ready;
  logic [27:0]  proc_addr, mem_addr;
  logic [127:0] proc_wdata, proc_rdata, mem_wdata, mem_rdata;
`ifdef DCACHE_L2_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int wait_n;

  dcache_l2_nway dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_ready (proc_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_L2_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [127:0] ln(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic check_stats(input string tag, input int exp_hit, input int exp_miss);
`ifdef DCACHE_L2_STATS_EN
    check({tag, "_hitcnt"}, hit_cnt, exp_hit);
    check({tag, "_misscnt"}, miss_cnt, exp_miss);
`endif
  endtask

  // Drive point is posedge+1; sample point is posedge+2.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] wd);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    #1;
  endtask

  task automatic release_req();
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  // Wait for a memory request, check it, then answer with a one-cycle mem_ready.
  // Returns at the sample point of the cycle where mem_ready_q is high.
  task automatic serve_mem(input logic is_wr, input logic [27:0] exp_addr,
                           input logic [127:0] exp_wdata, input logic [127:0] rdata,
                           input string tag);
    int n = 0;
    while (mem_read !== 1'b1 && mem_write !== 1'b1 && n < 8) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({tag, "_mwr"}, mem_write, is_wr);
    check({tag, "_mrd"}, mem_read, !is_wr);
    check({tag, "_maddr"}, mem_addr, exp_addr);
    if (is_wr) check({tag, "_mwdata"}, mem_wdata, exp_wdata);
    next_cycle();
    mem_rdata = rdata;
    mem_ready = 1'b1;
    next_cycle();
    mem_ready = 1'b0;
    #1;
  endtask

  task automatic hit_read(input logic [27:0] a, input logic [127:0] exp, input string tag);
    drive(1'b1, 1'b0, a, '0);
    check({tag, "_rdy"}, proc_ready, 1'b1);
    check({tag, "_rdata"}, proc_rdata, exp);
    check({tag, "_memidle"}, {mem_read, mem_write}, 2'b00);
    next_cycle();
    release_req();
  endtask

  task automatic write_now(input logic [27:0] a, input logic [127:0] wd, input string tag);
    drive(1'b0, 1'b1, a, wd);
    check({tag, "_rdy"}, proc_ready, 1'b1);
    check({tag, "_memidle"}, {mem_read, mem_write}, 2'b00);
    next_cycle();
    release_req();
  endtask

  task automatic read_miss_fill(input logic [27:0] a, input logic [127:0] rdata, input string tag);
    drive(1'b1, 1'b0, a, '0);
    check({tag, "_rdy0"}, proc_ready, 1'b0);
    serve_mem(1'b0, a, '0, rdata, tag);
    check({tag, "_rdy"}, proc_ready, 1'b1);
    check({tag, "_rdata"}, proc_rdata, rdata);
    next_cycle();
    release_req();
  endtask

  task automatic pulse_reset();
    release_req();
    proc_reset = 1'b1;
    #1;
    proc_reset = 1'b0;
    next_cycle();
  endtask

  initial begin
    // Reset with a write request present: nothing may respond.
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_addr  = 28'h10;
    proc_wdata = ln(8'hFF);
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_rdy", proc_ready, 1'b0);
    check("rst_mrd", mem_read, 1'b0);
    check("rst_mwr", mem_write, 1'b0);
    check("rst_maddr", mem_addr, 28'h0);
    check("rst_rdata", proc_rdata, 128'h0);
    check_stats("rst", 0, 0);
    release_req();
    proc_reset = 1'b0;
    next_cycle();

    // Cold read miss fills from memory, then the same line hits.
    read_miss_fill(28'h10, ln(8'hA1), "t1_miss");
    hit_read(28'h10, ln(8'hA1), "t1_hit");
    check_stats("t1", 1, 1);

    // Fill set 0, touch way0, then a dirty eviction of 0x10 on write miss.
    pulse_reset();
    check_stats("t2_rst", 0, 0);
    write_now(28'h08, ln(8'hB1), "t2_w08");
    write_now(28'h10, ln(8'hB2), "t2_w10");
    write_now(28'h18, ln(8'hB3), "t2_w18");
    write_now(28'h20, ln(8'hB4), "t2_w20");
    hit_read(28'h08, ln(8'hB1), "t2_r08");
    drive(1'b0, 1'b1, 28'h28, ln(8'hB5));
    check("t2_w28_rdy0", proc_ready, 1'b0);
    serve_mem(1'b1, 28'h10, ln(8'hB2), '0, "t2_wb");
    check("t2_w28_rdy", proc_ready, 1'b1);
    next_cycle();
    release_req();
    hit_read(28'h28, ln(8'hB5), "t2_r28");
    hit_read(28'h18, ln(8'hB3), "t2_r18");
    check_stats("t2", 3, 5);

    // Set 3 all dirty: read miss writes back way0, then fills it clean.
    write_now(28'h03, ln(8'hC0), "t3_w03");
    write_now(28'h0B, ln(8'hC1), "t3_w0b");
    write_now(28'h13, ln(8'hC2), "t3_w13");
    write_now(28'h1B, ln(8'hC3), "t3_w1b");
    drive(1'b1, 1'b0, 28'h23, '0);
    check("t3_r23_rdy0", proc_ready, 1'b0);
    serve_mem(1'b1, 28'h03, ln(8'hC0), '0, "t3_wb");
    check("t3_wb_done_rdy", proc_ready, 1'b0);
    serve_mem(1'b0, 28'h23, '0, ln(8'hC4), "t3_fill");
    check("t3_r23_rdy", proc_ready, 1'b1);
    check("t3_r23_rdata", proc_rdata, ln(8'hC4));
    next_cycle();
    release_req();
    hit_read(28'h0B, ln(8'hC1), "t3_r0b");
    hit_read(28'h13, ln(8'hC2), "t3_r13");
    hit_read(28'h1B, ln(8'hC3), "t3_r1b");
    // Way0 is now oldest and was filled clean: no write-back expected.
    read_miss_fill(28'h2B, ln(8'hC5), "t3_cleanvic");
    check_stats("t3", 6, 11);

    // Read and write together is no request.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 28'h0B, ln(8'hEE));
      check("t4_rdy", proc_ready, 1'b0);
      check("t4_mem", {mem_read, mem_write}, 2'b00);
      check("t4_maddr", mem_addr, 28'h0);
      next_cycle();
    end
    release_req();
    check_stats("t4", 6, 11);
    hit_read(28'h0B, ln(8'hC1), "t4_r0b");

    // Reset in the middle of a fill drops mem_read at once and empties the cache.
    drive(1'b1, 1'b0, 28'h45, '0);
    check("t5_rdy0", proc_ready, 1'b0);
    wait_n = 0;
    while (mem_read !== 1'b1 && wait_n < 8) begin
      @(posedge clk);
      #2;
      wait_n++;
    end
    check("t5_fill_mrd", mem_read, 1'b1);
    check("t5_fill_maddr", mem_addr, 28'h45);
    next_cycle();
    proc_reset = 1'b1;
    #1;
    check("t5_rst_mrd", mem_read, 1'b0);
    check("t5_rst_mwr", mem_write, 1'b0);
    check("t5_rst_rdy", proc_ready, 1'b0);
    check_stats("t5_rst", 0, 0);
    release_req();
    #1;
    proc_reset = 1'b0;
    next_cycle();
    #1;
    check("t5_idle_rdy", proc_ready, 1'b0);
    check("t5_idle_mrd", mem_read, 1'b0);
    next_cycle();
    read_miss_fill(28'h0B, ln(8'hD1), "t5_r0b_miss");

    // Counter totals since the last reset: 3 hits, 2 misses.
    hit_read(28'h0B, ln(8'hD1), "t6_h1");
    hit_read(28'h0B, ln(8'hD1), "t6_h2");
    hit_read(28'h0B, ln(8'hD1), "t6_h3");
    write_now(28'h0C, ln(8'hD2), "t6_w0c");
    check_stats("t6", 3, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
